// File: rtl/segre_store_drain_if.sv
// Shared memop type and the store-buffer / tag / data-array / fill bundle
// seen by the store drain engine.
package segre_store_drain_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } memop_data_type_e;
endpackage

interface segre_store_drain_if #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned CNT_SIZE  = 16
);
  logic                                    cache_busy_i;
  logic                                    sb_data_valid_i;
  logic [ADDR_SIZE-1:0]                    sb_addr_i;
  logic [WORD_SIZE-1:0]                    sb_data_i;
  segre_store_drain_pkg::memop_data_type_e sb_type_i;
  logic                                    flush_chance_o;
  logic                                    tag_req_o;
  logic [ADDR_SIZE-1:0]                    tag_addr_o;
  logic                                    tag_hit_i;
  logic                                    wr_en_o;
  logic [ADDR_SIZE-1:0]                    wr_addr_o;
  logic [WORD_SIZE-1:0]                    wr_data_o;
  logic [3:0]                              wr_be_o;
  logic                                    mem_req_o;
  logic [ADDR_SIZE-1:0]                    mem_addr_o;
  logic                                    mem_ack_i;
  logic                                    misaligned_o;
  logic [CNT_SIZE-1:0]                     drained_cnt_o;
  logic                                    idle_o;

  modport slave (
    input  cache_busy_i, sb_data_valid_i, sb_addr_i, sb_data_i, sb_type_i,
           tag_hit_i, mem_ack_i,
    output flush_chance_o, tag_req_o, tag_addr_o, wr_en_o, wr_addr_o,
           wr_data_o, wr_be_o, mem_req_o, mem_addr_o, misaligned_o,
           drained_cnt_o, idle_o
  );

  modport master (
    output cache_busy_i, sb_data_valid_i, sb_addr_i, sb_data_i, sb_type_i,
           tag_hit_i, mem_ack_i,
    input  flush_chance_o, tag_req_o, tag_addr_o, wr_en_o, wr_addr_o,
           wr_data_o, wr_be_o, mem_req_o, mem_addr_o, misaligned_o,
           drained_cnt_o, idle_o
  );
endinterface

// File: rtl/segre_store_drain.sv
// Store drain engine: pulls the oldest store-buffer entry, looks up the tag,
// fills the line on a miss, then commits one lane-shifted write to the data array.
module segre_store_drain
  import segre_store_drain_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned CNT_SIZE  = 16
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  segre_store_drain_if.slave   sd_if
);

  localparam int unsigned BE_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_CHECK  = 3'd2,
    S_FILL   = 3'd3,
    S_WRITE  = 3'd4
  } state_e;

  state_e               r_state, w_next;
  logic                 w_grant, w_take, w_misaligned;
  logic [1:0]           w_off;
  logic [BE_W-1:0]      w_be;
  logic [WORD_SIZE-1:0] w_data;

  logic [ADDR_SIZE-1:0] r_addr, r_waddr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [BE_W-1:0]      r_be;
  logic                 r_tag_req, r_wr_en, r_mem_req, r_misaligned, r_idle;
  logic [CNT_SIZE-1:0]  r_cnt;

  // Lane placement and alignment of the entry at the store buffer head
  always_comb begin
    w_off        = sd_if.sb_addr_i[1:0];
    w_be         = '0;
    w_data       = '0;
    w_misaligned = 1'b0;
    case (sd_if.sb_type_i)
      MEM_BYTE: begin
        w_be   = BE_W'(1) << w_off;
        w_data = WORD_SIZE'(sd_if.sb_data_i[7:0]) << {w_off, 3'b000};
      end
      MEM_HALF: begin
        w_be         = BE_W'(3) << w_off;
        w_data       = WORD_SIZE'(sd_if.sb_data_i[15:0]) << {w_off, 3'b000};
        w_misaligned = w_off[0];
      end
      default: begin
        w_be         = '1;
        w_data       = sd_if.sb_data_i;
        w_misaligned = (w_off != 2'b00);
      end
    endcase
  end

  // Next state; the grant is only offered from IDLE and never during reset
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant = !sd_if.cache_busy_i && !rsn_i;
        w_take  = w_grant && sd_if.sb_data_valid_i;
        if (w_take && !w_misaligned) w_next = S_LOOKUP;
      end
      S_LOOKUP: w_next = S_CHECK;
      S_CHECK:  w_next = sd_if.tag_hit_i ? S_WRITE : S_FILL;
      S_FILL:   if (sd_if.mem_ack_i) w_next = S_WRITE;
      S_WRITE:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_tag_req    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_misaligned <= 1'b0;
      r_idle       <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_next;
      r_tag_req    <= (w_next == S_LOOKUP);
      r_mem_req    <= (w_next == S_FILL);
      r_wr_en      <= (w_next == S_WRITE);
      r_idle       <= (w_next == S_IDLE);
      r_misaligned <= w_take && w_misaligned;
      if (w_take) begin
        r_addr  <= sd_if.sb_addr_i;
        r_waddr <= {sd_if.sb_addr_i[ADDR_SIZE-1:2], 2'b00};
        r_wdata <= w_data;
        r_be    <= w_be;
      end
      if (r_state == S_WRITE && r_cnt != '1) r_cnt <= r_cnt + CNT_SIZE'(1);
    end
  end

  assign sd_if.flush_chance_o = w_grant;
  assign sd_if.tag_req_o      = r_tag_req;
  assign sd_if.tag_addr_o     = r_addr;
  assign sd_if.wr_en_o        = r_wr_en;
  assign sd_if.wr_addr_o      = r_waddr;
  assign sd_if.wr_data_o      = r_wdata;
  assign sd_if.wr_be_o        = r_be;
  assign sd_if.mem_req_o      = r_mem_req;
  assign sd_if.mem_addr_o     = r_waddr;
  assign sd_if.misaligned_o   = r_misaligned;
  assign sd_if.drained_cnt_o  = r_cnt;
  assign sd_if.idle_o         = r_idle;

endmodule
